cpu_memory: RTL and testbench
=============================

Name: cpu_memory

Overview:
- 64 x 8 unified program/data memory for the SimpleCPU datapath.
- The controller drives a 6-bit address from its AR register and asserts READ.
- The memory drives the 8-bit shared data bus combinationally while READ is high, and floats it otherwise.
- Contents are restored to a fixed boot image on reset; an optional synchronous write port is available.

Parameters:
- ADDR_W, 6, address width; depth is 2**ADDR_W words (64).
- DATA_W, 8, word width; bits [7:6] are the opcode, bits [5:0] the operand address.

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  word address (full decode, no out-of-range case).
- READ  input  1  read enable; when high, the memory drives data.
- data  output  DATA_W  tri-state read data; high-Z when READ=0.
- WRITE  input  1  write enable (present only with MEM_WRITE_EN).
- wdata  input  DATA_W  write data (present only with MEM_WRITE_EN).

Behaviour:
- Storage: array mem[0..63] of 8-bit words.
- Read path: data = READ ? mem[address] : all-Z.
  - Purely combinational, zero-cycle latency. The controller samples the bus on the falling edge of the same cycle.
  - The memory never drives the bus while READ=0, so the PC and DR can share the bus.
- Reset:
  - On a rising clk edge with reset=1, every word is loaded from the boot image in the same edge.
  - Boot image: 0x00=0x04 (ADD 0x04), 0x01=0x45 (AND 0x05), 0x02=0xC0 (INC), 0x03=0x80 (JMP 0x00), 0x04=0x27, 0x05=0x39, all other addresses 0x00.
  - Power-up (initial) contents equal the boot image, so the block is usable before the first reset.
  - Reset does not affect the data port: if READ=1 during reset, data shows current contents, then the image after the edge.
  - Reset mid-operation discards all prior writes.
- Write (MEM_WRITE_EN only):
  - On a rising clk edge with WRITE=1 and reset=0, mem[address] <= wdata.
  - Reset has priority over WRITE in the same edge; the write is dropped.
- Read/write interaction:
  - With READ=1 and WRITE=1 at the same address, data shows the old word until the edge and the new word immediately after.
  - Write-through to the bus before the edge is not allowed.
- READ and WRITE may both be high; the read path is unaffected except through the updated contents.
- Address wraps naturally: 6-bit address, so 0x3F is the last word; no wrap logic is needed.
- No other outputs; no busy or ready signalling; every access completes in the cycle it is issued.

Optional Feature:
- Macro MEM_WRITE_EN.
- Defined:
  - WRITE and wdata ports exist.
  - Synchronous write behaves as described above; the array is RAM.
- Undefined:
  - WRITE and wdata ports are absent.
  - The array is read-only (ROM) holding the boot image.
  - Reset still executes but has no visible effect on contents.

Test Plan:
- Reset, then READ=1 with address stepped 0x00..0x07 -> data reads 0x04, 0x45, 0xC0, 0x80, 0x27, 0x39, 0x00, 0x00, with no clock latency.
- READ=0 at any address -> data = 8'hZZ. Toggle READ 0->1 with address=0x04 -> data becomes 0x27 combinationally.
- MEM_WRITE_EN: WRITE=1, address=0x3F, wdata=0xA5 for one edge; then READ at 0x3F -> 0xA5, and 0x3E is unchanged at 0x00.
- MEM_WRITE_EN: READ=1, WRITE=1, address=0x05, wdata=0x11 -> data reads 0x39 before the edge and 0x11 after the edge.
- MEM_WRITE_EN: write 0xFF to 0x00, then assert reset together with WRITE=1 and wdata=0x22 at 0x01 -> after the edge, 0x00 reads 0x04 and 0x01 reads 0x45.
- Without MEM_WRITE_EN: reset for one cycle mid-stream -> contents are unchanged boot image; data stays high-Z whenever READ=0.

Source files
------------

// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - 64x8 unified program/data memory with combinational tri-state read port.
// Optional synchronous write port enabled by defining MEM_WRITE_EN; otherwise the array is a boot-image ROM.
module cpu_memory #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              READ,
  output logic [DATA_W-1:0] data
`ifdef MEM_WRITE_EN
  ,
  input  logic              WRITE,
  input  logic [DATA_W-1:0] wdata
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

`ifdef MEM_WRITE_EN
  assign wr_en   = WRITE & ~reset;
  assign wr_data = wdata;
`else
  assign wr_en   = 1'b0;
  assign wr_data = '0;
`endif

  function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    case (a)
      ADDR_W'(0): w = DATA_W'(8'h04);
      ADDR_W'(1): w = DATA_W'(8'h45);
      ADDR_W'(2): w = DATA_W'(8'hC0);
      ADDR_W'(3): w = DATA_W'(8'h80);
      ADDR_W'(4): w = DATA_W'(8'h27);
      ADDR_W'(5): w = DATA_W'(8'h39);
      default:    w = '0;
    endcase
    return w;
  endfunction

  // A word reads from the RAM array only once written since the last reset;
  // otherwise the boot image shows through. Clearing the mask restores every
  // word in a single edge, and the power-up value gives boot contents pre-reset.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  dirty = '0;
  logic [DATA_W-1:0] word;

  always_ff @(posedge clk) begin
    if (reset) begin
      dirty <= '0;
    end else if (wr_en) begin
      dirty[address] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[address] <= wr_data;
    end
  end

  always_comb begin
    word = boot_word(address);
    if (dirty[address]) begin
      word = mem[address];
    end
  end

  assign data = READ ? word : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cpu_memory.sv
// tb/tb_cpu_memory.sv - directed self-checking bench for cpu_memory (write tests built with MEM_WRITE_EN).
module tb_cpu_memory;

  logic       clk;
  logic       reset;
  logic [5:0] address;
  logic       READ;
  wire  [7:0] data;
`ifdef MEM_WRITE_EN
  logic       WRITE;
  logic [7:0] wdata;
`endif

  int n_checks;
  int n_fail;
  logic [7:0] boot_exp [8];

  cpu_memory dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .READ    (READ),
    .data    (data)
`ifdef MEM_WRITE_EN
    ,
    .WRITE   (WRITE),
    .wdata   (wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Power-up contents must already be the boot image.
    READ = 1'b1;
    address = 6'h01;
    #1;
    n_checks++;
    if (data !== 8'h45) begin
      n_fail++;
      $display("FAIL powerup_read: got %h expected %h", data, 8'h45);
    end
    reset = 1'b1;
    address = 6'h04;
    #1;
    n_checks++;
    if (data !== 8'h27) begin
      n_fail++;
      $display("FAIL read_during_reset: got %h expected %h", data, 8'h27);
    end
    after_edge();
    reset = 1'b0;
    address = 6'h00;
    #1;
    n_checks++;
    if (data !== 8'h04) begin
      n_fail++;
      $display("FAIL post_reset_read: got %h expected %h", data, 8'h04);
    end
  endtask

  task automatic test_read_sweep();
    READ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 6'(i);
      #1;
      n_checks++;
      if (data !== boot_exp[i]) begin
        n_fail++;
        $display("FAIL read_sweep[%0d]: got %h expected %h", i, data, boot_exp[i]);
      end
    end
  endtask

  task automatic test_read_disable();
    logic [7:0] zz;
    zz = 8'hzz;
    READ = 1'b0;
    for (int i = 0; i < 6; i++) begin
      address = 6'(i);
      #1;
      n_checks++;
      if (data !== zz) begin
        n_fail++;
        $display("FAIL read_disable[%0d]: got %h expected %h", i, data, zz);
      end
    end
    address = 6'h04;
    #1;
    READ = 1'b1;
    #1;
    n_checks++;
    if (data !== 8'h27) begin
      n_fail++;
      $display("FAIL read_toggle: got %h expected %h", data, 8'h27);
    end
    READ = 1'b0;
  endtask

`ifdef MEM_WRITE_EN
  task automatic test_write();
    after_edge();
    READ = 1'b0;
    WRITE = 1'b1;
    address = 6'h3F;
    wdata = 8'hA5;
    after_edge();
    WRITE = 1'b0;
    READ = 1'b1;
    #1;
    n_checks++;
    if (data !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_3f: got %h expected %h", data, 8'hA5);
    end
    address = 6'h3E;
    #1;
    n_checks++;
    if (data !== 8'h00) begin
      n_fail++;
      $display("FAIL neighbour_3e: got %h expected %h", data, 8'h00);
    end
  endtask

  task automatic test_rw_same_addr();
    READ = 1'b1;
    WRITE = 1'b1;
    address = 6'h05;
    wdata = 8'h11;
    #1;
    n_checks++;
    if (data !== 8'h39) begin
      n_fail++;
      $display("FAIL rw_before_edge: got %h expected %h", data, 8'h39);
    end
    after_edge();
    n_checks++;
    if (data !== 8'h11) begin
      n_fail++;
      $display("FAIL rw_after_edge: got %h expected %h", data, 8'h11);
    end
    WRITE = 1'b0;
  endtask

  task automatic test_reset_priority();
    WRITE = 1'b1;
    address = 6'h00;
    wdata = 8'hFF;
    after_edge();
    WRITE = 1'b0;
    #1;
    n_checks++;
    if (data !== 8'hFF) begin
      n_fail++;
      $display("FAIL write_00: got %h expected %h", data, 8'hFF);
    end
    reset = 1'b1;
    WRITE = 1'b1;
    address = 6'h01;
    wdata = 8'h22;
    after_edge();
    reset = 1'b0;
    WRITE = 1'b0;
    address = 6'h00;
    #1;
    n_checks++;
    if (data !== 8'h04) begin
      n_fail++;
      $display("FAIL reset_restores_00: got %h expected %h", data, 8'h04);
    end
    address = 6'h01;
    #1;
    n_checks++;
    if (data !== 8'h45) begin
      n_fail++;
      $display("FAIL reset_drops_write_01: got %h expected %h", data, 8'h45);
    end
    address = 6'h3F;
    #1;
    n_checks++;
    if (data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_restores_3f: got %h expected %h", data, 8'h00);
    end
    address = 6'h05;
    #1;
    n_checks++;
    if (data !== 8'h39) begin
      n_fail++;
      $display("FAIL reset_restores_05: got %h expected %h", data, 8'h39);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    logic [7:0] zz;
    zz = 8'hzz;
    READ = 1'b1;
    address = 6'h02;
    after_edge();
    READ = 1'b0;
    reset = 1'b1;
    address = 6'h03;
    #1;
    n_checks++;
    if (data !== zz) begin
      n_fail++;
      $display("FAIL z_during_reset: got %h expected %h", data, zz);
    end
    after_edge();
    reset = 1'b0;
    READ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 6'(i);
      #1;
      n_checks++;
      if (data !== boot_exp[i]) begin
        n_fail++;
        $display("FAIL midstream_read[%0d]: got %h expected %h", i, data, boot_exp[i]);
      end
    end
    READ = 1'b0;
    #1;
    n_checks++;
    if (data !== zz) begin
      n_fail++;
      $display("FAIL z_after_reset: got %h expected %h", data, zz);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    boot_exp[0] = 8'h04;
    boot_exp[1] = 8'h45;
    boot_exp[2] = 8'hC0;
    boot_exp[3] = 8'h80;
    boot_exp[4] = 8'h27;
    boot_exp[5] = 8'h39;
    boot_exp[6] = 8'h00;
    boot_exp[7] = 8'h00;
    reset = 1'b0;
    READ = 1'b0;
    address = '0;
`ifdef MEM_WRITE_EN
    WRITE = 1'b0;
    wdata = '0;
`endif
    #2;
    test_reset();
    test_read_sweep();
    test_read_disable();
`ifdef MEM_WRITE_EN
    test_write();
    test_rw_same_addr();
    test_reset_priority();
`endif
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
